obc_oam_engine: RTL and testbench

Parametrised successor to the OBC1 object-attribute coprocessor for the SNES cart window. Holds N banks of sprite OAM, each with a 4-byte low entry and a 2-bit high entry per object. Access is either direct (raw table windows) or through an indexed register port with optional auto-increment. Adds a sequential bank engine that copies the active bank to the next bank, or fills the active bank, while the SNES keeps running.

---
 rtl/obc_oam_engine.sv | 214 +++++++++++++++++++++
 tb/tb_obc_oam_engine.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/obc_oam_engine.sv
// OBC-style sprite OAM coprocessor: banked low/high attribute tables, direct and indexed
// SNES access, plus a background engine that copies a bank to its successor or fills it.
module obc_oam_engine #(
    parameter int          OBJ_BITS  = 7,
    parameter int          BANK_BITS = 1,
    parameter logic [7:0]  FILL_HIGH = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [12:0] addr_in,
    input  logic [7:0]  data_in,
    input  logic        reg_we_rising,
    output logic [7:0]  data_out,
    output logic        busy
);
    localparam int LAW = OBJ_BITS + 2 + BANK_BITS;
    localparam int HAW = OBJ_BITS - 2 + BANK_BITS;
    localparam int CW  = OBJ_BITS + 3;
    localparam int BIW = BANK_BITS + OBJ_BITS;
    localparam logic [CW-1:0] LB_C   = CW'(1 << (OBJ_BITS + 2));
    localparam logic [CW-1:0] LAST_C = CW'((1 << (OBJ_BITS + 2)) + (1 << (OBJ_BITS - 2)) - 1);
    localparam logic [1:0] SEL_REG = 2'd0, SEL_LOW = 2'd1, SEL_HIGH = 2'd2;

    typedef enum logic [1:0] {IDLE, CP_RD, CP_WR, FILL} state_t;
    state_t state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    logic [7:0] low_mem  [0:(1 << LAW) - 1];
    logic [7:0] high_mem [0:(1 << HAW) - 1];

    logic [BANK_BITS-1:0] bank, ebank, dbank;
    logic                 autoinc;
    logic [OBJ_BITS-1:0]  idx;
    logic [7:0]           fill_byte, efill;
    logic [7:0]           low_q, high_q, eng_low_q, eng_high_q, reg_q, reg_rd;
    logic [1:0]           sel_reg, sel_next;

    logic                 rmw_pend;
    logic [HAW-1:0]       rmw_addr;
    logic [1:0]           rmw_slot, rmw_bits;
    logic [7:0]           rmw_byte;

    // Address decode, everything qualified by enable
    logic       we, dir_low, dir_high, reg_hit;
    logic [2:0] reg_sel;
    assign we       = enable & reg_we_rising;
    assign dir_low  = enable & ~addr_in[12];
    assign dir_high = enable & (addr_in[12:11] == 2'b10);
    assign reg_hit  = enable & (addr_in[12:3] == 10'h3FE);
    assign reg_sel  = addr_in[2:0];

    logic [BIW-1:0] bank_idx;
    logic [LAW-1:0] port_low_addr, a_low_addr;
    logic [HAW-1:0] port_high_addr, a_high_addr;
    assign bank_idx       = {bank, idx};
    assign port_low_addr  = {bank_idx, addr_in[1:0]};
    assign port_high_addr = bank_idx[BIW-1:2];
    assign a_low_addr     = dir_low  ? addr_in[LAW-1:0] : port_low_addr;
    assign a_high_addr    = dir_high ? addr_in[HAW-1:0] : port_high_addr;

    logic snes_low_we, snes_high_we, port_hi_we, start_copy, start_fill;
    assign snes_low_we  = we & ~busy & (dir_low | (reg_hit & ~reg_sel[2]));
    assign snes_high_we = we & ~busy & dir_high;
    assign port_hi_we   = we & ~busy & reg_hit & (reg_sel == 3'd4);
    assign start_copy   = we & ~busy & reg_hit & (reg_sel == 3'd5) & data_in[7];
    assign start_fill   = we & ~busy & reg_hit & (reg_sel == 3'd7);

    // Engine walks the low table first (cnt < LB), then the high table
    logic           in_high;
    logic [LAW-1:0] e_src_low, e_dst_low;
    logic [HAW-1:0] e_src_high, e_dst_high;
    assign in_high    = (cnt_reg >= LB_C);
    assign dbank      = ebank + BANK_BITS'(1);
    assign e_src_low  = {ebank, cnt_reg[OBJ_BITS+1:0]};
    assign e_dst_low  = {dbank, cnt_reg[OBJ_BITS+1:0]};
    assign e_src_high = (HAW'(ebank) << (OBJ_BITS - 2)) | HAW'(cnt_reg - LB_C);
    assign e_dst_high = (HAW'(dbank) << (OBJ_BITS - 2)) | HAW'(cnt_reg - LB_C);
    assign busy       = (state_reg != IDLE);

    logic       eng_wr, eng_use_dst;
    logic [7:0] eng_data;

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        eng_wr      = 1'b0;
        eng_use_dst = 1'b0;
        eng_data    = 8'h00;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (start_copy)      state_next = CP_RD;
                else if (start_fill) state_next = FILL;
            end
            CP_RD: state_next = CP_WR;
            CP_WR: begin
                eng_wr      = 1'b1;
                eng_use_dst = 1'b1;
                eng_data    = in_high ? eng_high_q : eng_low_q;
                if (cnt_reg == LAST_C) state_next = IDLE;
                else begin
                    cnt_next   = cnt_reg + 1'b1;
                    state_next = CP_RD;
                end
            end
            FILL: begin
                eng_wr   = 1'b1;
                eng_data = in_high ? FILL_HIGH : efill;
                if (cnt_reg == LAST_C) state_next = IDLE;
                else cnt_next = cnt_reg + 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        rmw_byte = high_q;
        rmw_byte[{rmw_slot, 1'b0} +: 2] = rmw_bits;
    end

    always_comb begin
        reg_rd   = 8'h77;
        sel_next = SEL_REG;
        if (!enable) begin
            reg_rd = 8'h00;
        end else if (dir_low || (reg_hit && !reg_sel[2])) begin
            sel_next = SEL_LOW;
        end else if (dir_high || (reg_hit && reg_sel == 3'd4)) begin
            sel_next = SEL_HIGH;
        end else if (reg_hit) begin
            case (reg_sel)
                3'd5: begin
                    reg_rd                = 8'h00;
                    reg_rd[7]             = busy;
                    reg_rd[6]             = autoinc;
                    reg_rd[BANK_BITS-1:0] = bank;
                end
                3'd6:    reg_rd = 8'(idx);
                default: reg_rd = fill_byte;
            endcase
        end
    end

    always_comb begin
        case (sel_reg)
            SEL_LOW:  data_out = low_q;
            SEL_HIGH: data_out = high_q;
            default:  data_out = reg_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            bank      <= '0;
            ebank     <= '0;
            autoinc   <= 1'b0;
            idx       <= '0;
            fill_byte <= 8'h00;
            efill     <= 8'h00;
            rmw_pend  <= 1'b0;
            rmw_addr  <= '0;
            rmw_slot  <= 2'd0;
            rmw_bits  <= 2'd0;
            sel_reg   <= SEL_REG;
            reg_q     <= 8'h00;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sel_reg   <= sel_next;
            reg_q     <= reg_rd;
            rmw_pend  <= port_hi_we;
            if (port_hi_we) begin
                rmw_addr <= port_high_addr;
                rmw_slot <= idx[1:0];
                rmw_bits <= data_in[1:0];
            end
            if (start_copy || start_fill) ebank <= bank;
            if (start_fill) efill <= data_in;
            if (we && reg_hit) begin
                case (reg_sel)
                    3'd3: if (autoinc && !busy) idx <= idx + 1'b1;
                    3'd5: begin
                        bank    <= data_in[BANK_BITS-1:0];
                        autoinc <= data_in[6];
                    end
                    3'd6: idx <= data_in[OBJ_BITS-1:0];
                    3'd7: fill_byte <= data_in;
                    default: ;
                endcase
            end
        end
    end

    // Tables: SNES read port, engine read port, one shared write port (engine has priority)
    always_ff @(posedge clk) begin
        low_q      <= low_mem[a_low_addr];
        high_q     <= high_mem[a_high_addr];
        eng_low_q  <= low_mem[e_src_low];
        eng_high_q <= high_mem[e_src_high];
        if (eng_wr && !in_high)
            low_mem[eng_use_dst ? e_dst_low : e_src_low] <= eng_data;
        else if (snes_low_we)
            low_mem[a_low_addr] <= data_in;
        if (eng_wr && in_high)
            high_mem[eng_use_dst ? e_dst_high : e_src_high] <= eng_data;
        else if (rmw_pend)
            high_mem[rmw_addr] <= rmw_byte;
        else if (snes_high_we)
            high_mem[a_high_addr] <= data_in;
    end
endmodule

// File: tb/tb_obc_oam_engine.sv
// Bench for obc_oam_engine: random and directed SNES traffic checked against a table-level model.
module tb_obc_oam_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [12:0] addr_in = 13'h0;
    logic [7:0]  data_in = 8'h00;
    logic        reg_we_rising = 1'b0;
    logic [7:0]  data_out;
    logic        busy;

    obc_oam_engine dut (
        .clk(clk), .rst(rst), .enable(enable), .addr_in(addr_in), .data_in(data_in),
        .reg_we_rising(reg_we_rising), .data_out(data_out), .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: tables as flat arrays, registers as plain variables
    logic [7:0] m_low [1024];
    logic [7:0] m_high [64];
    logic [6:0] m_idx = 0;
    logic       m_bank = 0;
    logic       m_autoinc = 0;
    logic [7:0] m_fill = 0;
    logic       m_busy = 0;

    function automatic bit is_reg(input logic [12:0] a);
        return (a >= 13'h1FF0) && (a <= 13'h1FF7);
    endfunction

    function automatic void m_write(input logic [12:0] a, input logic [7:0] d);
        int k, slot;
        if (a < 13'h1000) m_low[a % 1024] = d;
        else if (a < 13'h1800) m_high[a % 64] = d;
        else if (is_reg(a)) begin
            case (a - 13'h1FF0)
                0, 1, 2, 3: begin
                    m_low[int'(m_bank) * 512 + int'(m_idx) * 4 + int'(a - 13'h1FF0)] = d;
                    if (a == 13'h1FF3 && m_autoinc) m_idx = 7'((int'(m_idx) + 1) % 128);
                end
                4: begin
                    k = int'(m_bank) * 32 + int'(m_idx) / 4;
                    slot = int'(m_idx) % 4;
                    m_high[k] = (m_high[k] & ~(8'h03 << (2 * slot))) | ((d & 8'h03) << (2 * slot));
                end
                5: begin m_bank = d[0]; m_autoinc = d[6]; end
                6: m_idx = d[6:0];
                default: m_fill = d;
            endcase
        end
    endfunction

    function automatic logic [7:0] m_read(input logic [12:0] a);
        if (a < 13'h1000) return m_low[a % 1024];
        if (a < 13'h1800) return m_high[a % 64];
        if (!is_reg(a)) return 8'h77;
        case (a - 13'h1FF0)
            0, 1, 2, 3: return m_low[int'(m_bank) * 512 + int'(m_idx) * 4 + int'(a - 13'h1FF0)];
            4: return m_high[int'(m_bank) * 32 + int'(m_idx) / 4];
            5: return (m_busy ? 8'h80 : 8'h00) | (m_autoinc ? 8'h40 : 8'h00) | 8'(m_bank);
            6: return 8'(m_idx);
            default: return m_fill;
        endcase
    endfunction

    function automatic void m_copy(input int src);
        int dst = (src + 1) % 2;
        for (int i = 0; i < 512; i++) m_low[dst * 512 + i] = m_low[src * 512 + i];
        for (int i = 0; i < 32; i++) m_high[dst * 32 + i] = m_high[src * 32 + i];
    endfunction

    function automatic void m_fill_bank(input int b, input logic [7:0] v);
        for (int i = 0; i < 512; i++) m_low[b * 512 + i] = v;
        for (int i = 0; i < 32; i++) m_high[b * 32 + i] = 8'h00;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic [12:0] a, input logic [7:0] d);
        addr_in = a; data_in = d; reg_we_rising = 1'b1;
        @(posedge clk); #1;
        reg_we_rising = 1'b0;
    endtask

    task automatic wr(input logic [12:0] a, input logic [7:0] d);
        pulse(a, d);
        repeat (3) @(posedge clk);
        #1;
        m_write(a, d);
    endtask

    task automatic chk_rd(input string tag, input logic [12:0] a);
        addr_in = a;
        @(posedge clk); #1;
        check($sformatf("%s@%h", tag, a), 32'(data_out), 32'(m_read(a)));
    endtask

    task automatic verify_all(input string tag);
        for (int i = 0; i < 1024; i++) chk_rd({tag, "_low"}, 13'(i));
        for (int i = 0; i < 64; i++) chk_rd({tag, "_high"}, 13'h1000 + 13'(i));
    endtask

    // Counts busy cycles after a start pulse; optionally drops in a direct write or a CTRL probe
    task automatic wait_engine(input int inject_at, input int probe_at, output int n);
        n = 0;
        while (busy && n < 5000) begin
            n++;
            if (n == inject_at) pulse(13'h0300, ~m_low[768]);
            else begin
                if (probe_at != 0) addr_in = 13'h1FF5;
                @(posedge clk); #1;
                if (n == probe_at) check("ctrl_busy_bit", 32'(data_out), 32'(m_read(13'h1FF5)));
            end
        end
    endtask

    initial begin
        logic [12:0] a;
        logic [7:0]  d;
        int          n, kind;

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_dout", 32'(data_out), 32'h00);
        rst = 1'b0;
        enable = 1'b1;
        chk_rd("reset_ctrl", 13'h1FF5);
        chk_rd("reset_idx", 13'h1FF6);
        chk_rd("reset_fill", 13'h1FF7);

        for (int i = 0; i < 1024; i++) wr(13'(i), 8'($urandom));
        for (int i = 0; i < 64; i++) wr(13'h1000 + 13'(i), 8'($urandom));

        // Random mixed traffic, no engine starts
        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 4);
            d = 8'($urandom);
            case (kind)
                0: a = 13'($urandom_range(0, 13'h0FFF));
                1: a = 13'h1000 + 13'($urandom_range(0, 13'h07FF));
                2: a = 13'h1FF0 + 13'($urandom_range(0, 7));
                default: a = 13'h1800 + 13'($urandom_range(0, 13'h07EF));
            endcase
            if ($urandom_range(0, 1) == 0) chk_rd("rand_rd", a);
            else if (a != 13'h1FF7) wr(a, (a == 13'h1FF5) ? (d & 8'h7F) : d);
        end
        chk_rd("unmapped_hi", 13'h1FF8);

        // Indexed write then direct readback
        wr(13'h1FF5, 8'h01);
        wr(13'h1FF6, 8'h05);
        wr(13'h1FF0, 8'h11); wr(13'h1FF1, 8'h22); wr(13'h1FF2, 8'h33); wr(13'h1FF3, 8'h44);
        for (int i = 0; i < 4; i++) chk_rd("idx_write", 13'h0214 + 13'(i));
        addr_in = 13'h0217; @(posedge clk); #1;
        check("idx_write_const", 32'(data_out), 32'h44);

        // Auto-increment wrap
        wr(13'h1FF5, 8'h40);
        wr(13'h1FF6, 8'h7F);
        for (int i = 0; i < 4; i++) wr(13'h1FF0 + 13'(i), 8'($urandom));
        chk_rd("autoinc_wrap", 13'h1FF6);
        for (int i = 0; i < 4; i++) chk_rd("obj127", 13'h01FC + 13'(i));
        wr(13'h1FF2, 8'h5A);
        chk_rd("no_inc_1ff2", 13'h1FF6);
        check("no_inc_const", 32'(data_out), 32'h00);

        // High-table slot read-modify-write
        wr(13'h1FF5, 8'h00);
        wr(13'h1001, 8'h00);
        wr(13'h1FF6, 8'h06); wr(13'h1FF4, 8'hFF);
        wr(13'h1FF6, 8'h07); wr(13'h1FF4, 8'h01);
        chk_rd("high_direct", 13'h1001);
        check("high_const", 32'(data_out), 32'h70);
        chk_rd("high_port", 13'h1FF4);

        // Write without enable is ignored
        enable = 1'b0;
        pulse(13'h0005, ~m_low[5]);
        enable = 1'b1;
        chk_rd("no_enable", 13'h0005);

        // FILL bank 0, with a direct write into bank 1 while busy
        pulse(13'h1FF7, 8'hA5);
        m_fill = 8'hA5;
        wait_engine(10, 0, n);
        check("fill_len", 32'(n), 32'd544);
        m_fill_bank(0, 8'hA5);
        verify_all("fill");

        // COPY bank 1 -> bank 0
        wr(13'h1FF5, 8'h01);
        pulse(13'h1FF5, 8'h81);
        m_busy = 1'b1;
        wait_engine(0, 20, n);
        m_busy = 1'b0;
        check("copy_len", 32'(n), 32'd1088);
        m_copy(1);
        chk_rd("ctrl_idle", 13'h1FF5);
        verify_all("copy");

        // Reset in the middle of a copy into bank 0, then a fresh fill of bank 0
        wr(13'h1FF6, 8'h09);
        pulse(13'h1FF5, 8'hC1);
        repeat (299) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_dout", 32'(data_out), 32'h00);
        #2;
        rst = 1'b0;
        m_idx = 0; m_bank = 0; m_autoinc = 0; m_fill = 0;
        chk_rd("rst_ctrl", 13'h1FF5);
        chk_rd("rst_idx", 13'h1FF6);
        chk_rd("rst_fill", 13'h1FF7);
        pulse(13'h1FF7, 8'h3C);
        m_fill = 8'h3C;
        wait_engine(0, 0, n);
        check("refill_len", 32'(n), 32'd544);
        m_fill_bank(0, 8'h3C);
        verify_all("refill");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
